instr_fetch_responder: RTL and testbench
========================================

INSTR_FETCH_RESPONDER -- requirements
Module: instr_fetch_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, instruction address width.
REQ-002 SHALL have parameter DATA_W, default 8, instruction width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port fetch_req  input  1  fetch request, level, held until fetch_ack.
REQ-006 SHALL have port fetch_addr  input  ADDR_W  fetch address, stable while fetch_req high.
REQ-007 SHALL have port fetch_ack  output  1  one-cycle pulse; fetch_data valid in this cycle.
REQ-008 SHALL have port fetch_data  output  DATA_W  instruction returned.
REQ-009 SHALL have port load_start  input  1  pulse; begin program load at address 0.
REQ-010 SHALL have port load_valid  input  1  load_data valid.
REQ-011 SHALL have port load_data  input  DATA_W  program byte to store.
REQ-012 SHALL have port load_done  input  1  end load after the current beat.
REQ-013 SHALL have port load_ready  output  1  high only in LOADING.
REQ-014 SHALL have port prog_valid  output  1  high when in READY/FETCH.

Function
REQ-015 SHALL hold 2**ADDR_W x DATA_W storage, write pointer wr_ptr (ADDR_W bits), FSM states IDLE, LOADING, READY, FETCH.
REQ-016 SHALL, in IDLE, ignore fetch_req (fetch_ack stays 0) and wait for load_start.
REQ-017 SHALL, on load_start in any state, enter LOADING next edge with wr_ptr=0; an in-progress fetch is aborted with no ack.
REQ-018 SHALL, in LOADING, write load_data to mem[wr_ptr] and increment wr_ptr on each edge with load_valid=1; beats with load_valid=0 are ignored.
REQ-019 SHALL enter READY after the edge where load_done=1 (that cycle's valid beat is written first) or after writing wr_ptr = 2**ADDR_W-1 (wrap ends load; wr_ptr returns to 0).
REQ-020 SHALL ignore load_done outside LOADING; load_start has priority over load_done in the same cycle.
REQ-021 SHALL, in READY with fetch_req=1 at edge N, capture fetch_addr and enter FETCH; read memory at edge N+1; assert fetch_ack=1 with fetch_data=mem[addr] during cycle after edge N+2; return to READY on that ack edge.
REQ-022 SHALL keep fetch_ack high exactly one cycle per request; requestor must drop or change fetch_req after ack; a still-high fetch_req in READY starts a new fetch.
REQ-023 SHALL hold fetch_data at last returned value between acks.
REQ-024 SHALL not service fetches during LOADING; fetch_req is stalled until READY.

Reset
REQ-025 SHALL, on rst_n=0, asynchronously force state IDLE, wr_ptr=0, fetch_ack=0, fetch_data=0, load_ready=0, prog_valid=0; memory contents not reset.
REQ-026 SHALL resume from IDLE on first rising edge after rst_n deasserts; reset mid-load or mid-fetch discards the operation.

Configuration
REQ-027 SHALL, with macro INSTR_PREFETCH_EN defined, keep a one-entry prefetch buffer (pf_addr, pf_data, pf_valid) filled with mem[addr+1] (mod 2**ADDR_W) on each ack edge.
REQ-028 SHALL, with INSTR_PREFETCH_EN, ack a READY request whose fetch_addr equals pf_addr with pf_valid=1 in the cycle after edge N (latency 1), returning pf_data and refilling buffer for next address; mismatches use REQ-021 latency.
REQ-029 SHALL clear pf_valid on reset and load_start, and on any write in LOADING.
REQ-030 SHALL, without INSTR_PREFETCH_EN, have no prefetch logic; every fetch uses REQ-021 latency.

Verification
REQ-031 SHALL cover: reset, fetch_req=1 addr 0x00 without load -> fetch_ack stays 0 for 20 cycles, prog_valid=0.
REQ-032 SHALL cover: load_start, bytes 0x11,0x22,0x33 with load_done on third -> prog_valid=1; fetch addr 0x02 -> ack 2 cycles after request edge, data 0x33.
REQ-033 SHALL cover: load 256 beats 0x00..0xFF with no load_done -> READY after 256th write; fetch 0xFF -> 0xFF, fetch 0x00 -> 0x00.
REQ-034 SHALL cover: load_start asserted during FETCH -> no ack, load_ready=1 next cycle; gapped load_valid beats stored contiguously.
REQ-035 SHALL cover: rst_n low mid-load at beat 5 -> all outputs 0 immediately, IDLE after release.
REQ-036 SHALL cover (INSTR_PREFETCH_EN): fetch 0x10 then 0x11 -> second ack 1 cycle after request edge; then 0x40 -> 2-cycle latency; wrap fetch 0xFF then 0x00 -> 1-cycle latency.

Source files
------------

// File: rtl/instr_fetch_responder.sv
// Instruction store: loaded beat by beat from address 0, then serves single-word fetches.
// Fetch latency: ack 2 edges after the request edge; with INSTR_PREFETCH_EN, a prefetch hit acks on the request edge itself.
// Backpressure: load_ready is high only while loading; fetch_req is held until fetch_ack and is stalled outside READY.
module instr_fetch_responder #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ack,
    output logic [DATA_W-1:0] fetch_data,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_done,
    output logic              load_ready,
    output logic              prog_valid
);

    localparam int                DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {IDLE, LOADING, READY, FETCH} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] addr_q;
    logic              fetch_phase;   // 0: memory read pending, 1: ack pending
    logic [DATA_W-1:0] rd_dat;
    logic              wr_en;

    // A load_start beat restarts the load rather than storing data.
    assign wr_en = (state == LOADING) && !load_start && load_valid;

`ifdef INSTR_PREFETCH_EN
    logic [ADDR_W-1:0] pf_addr;
    logic [DATA_W-1:0] pf_data;
    logic              pf_valid;
    logic              pf_hit;
    logic [ADDR_W-1:0] req_next_addr;
    logic [ADDR_W-1:0] q_next_addr;

    assign pf_hit        = pf_valid && (fetch_addr == pf_addr);
    assign req_next_addr = fetch_addr + ADDR_W'(1);
    assign q_next_addr   = addr_q + ADDR_W'(1);
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and status outputs; load_start overrides everything.
    always_comb begin
        state_nxt  = state;
        load_ready = (state == LOADING);
        prog_valid = (state == READY) || (state == FETCH);
        if (load_start) begin
            state_nxt = LOADING;
        end else begin
            case (state)
                IDLE:    state_nxt = IDLE;
                LOADING: begin
                    if (load_done || (load_valid && (wr_ptr == LAST_ADDR))) begin
                        state_nxt = READY;
                    end
                end
                READY: begin
                    if (fetch_req) begin
`ifdef INSTR_PREFETCH_EN
                        state_nxt = pf_hit ? READY : FETCH;
`else
                        state_nxt = FETCH;
`endif
                    end
                end
                FETCH: begin
                    if (fetch_phase) begin
                        state_nxt = READY;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Program storage; deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= load_data;
        end
    end

    // Write pointer, fetch pipeline and the registered ack/data outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            addr_q      <= '0;
            fetch_phase <= 1'b0;
            rd_dat      <= '0;
            fetch_ack   <= 1'b0;
            fetch_data  <= '0;
        end else begin
            fetch_ack <= 1'b0;
            if (load_start) begin
                wr_ptr      <= '0;
                fetch_phase <= 1'b0;
            end else begin
                case (state)
                    LOADING: begin
                        if (load_valid) begin
                            wr_ptr <= wr_ptr + ADDR_W'(1);
                        end
                    end
                    READY: begin
                        if (fetch_req) begin
                            addr_q      <= fetch_addr;
                            fetch_phase <= 1'b0;
`ifdef INSTR_PREFETCH_EN
                            if (pf_hit) begin
                                fetch_ack  <= 1'b1;
                                fetch_data <= pf_data;
                            end
`endif
                        end
                    end
                    FETCH: begin
                        if (!fetch_phase) begin
                            rd_dat      <= mem[addr_q];
                            fetch_phase <= 1'b1;
                        end else begin
                            fetch_ack   <= 1'b1;
                            fetch_data  <= rd_dat;
                            fetch_phase <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef INSTR_PREFETCH_EN
    // Prefetch buffer: refilled with the following word on every ack edge, dropped on any program change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pf_addr  <= '0;
            pf_data  <= '0;
            pf_valid <= 1'b0;
        end else if (load_start || wr_en) begin
            pf_valid <= 1'b0;
        end else if ((state == READY) && fetch_req && pf_hit) begin
            pf_addr  <= req_next_addr;
            pf_data  <= mem[req_next_addr];
            pf_valid <= 1'b1;
        end else if ((state == FETCH) && fetch_phase) begin
            pf_addr  <= q_next_addr;
            pf_data  <= mem[q_next_addr];
            pf_valid <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Randomized bench for instr_fetch_responder against a word-array program model.
// Latency: checks the number of edges from the request to the ack against the expected hit/miss latency.
// Backpressure: drives fetch_req as a level held until ack; load beats may have random gaps.
module tb_instr_fetch_responder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       fetch_req;
    logic [7:0] fetch_addr;
    logic       fetch_ack;
    logic [7:0] fetch_data;
    logic       load_start;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_done;
    logic       load_ready;
    logic       prog_valid;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: program contents plus the one-word prefetch buffer.
    logic [7:0] m_mem [256];
    logic [7:0] m_pf_addr = 8'd0;
    logic       m_pf_vld  = 1'b0;

    instr_fetch_responder #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_ack  (fetch_ack),
        .fetch_data (fetch_data),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_done  (load_done),
        .load_ready (load_ready),
        .prog_valid (prog_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Miss: ack visible after the third edge counted from raising the request; hit: after the first.
    task automatic do_fetch(input logic [7:0] a);
        int lat;
        int exp_lat;
        exp_lat = 3;
`ifdef INSTR_PREFETCH_EN
        if (m_pf_vld && (m_pf_addr == a)) exp_lat = 1;
`endif
        fetch_req  = 1'b1;
        fetch_addr = a;
        lat        = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (fetch_ack) begin
                lat = k;
                break;
            end
        end
        fetch_req = 1'b0;
        chk("fetch_lat", lat, exp_lat);
        chk("fetch_data", 32'(fetch_data), 32'(m_mem[a]));
        m_pf_addr = a + 8'd1;
        m_pf_vld  = 1'b1;
        tick();
        chk("ack_pulse", 32'(fetch_ack), 32'd0);
        chk("data_hold", 32'(fetch_data), 32'(m_mem[a]));
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("load_ready_on", 32'(load_ready), 32'd1);
        chk("prog_valid_ld", 32'(prog_valid), 32'd0);
        m_pf_vld = 1'b0;
    endtask

    // mode 0: data = index, 1: random, 2: 0x11,0x22,0x33...
    task automatic load_beats(input int n, input bit gaps, input int mode, input bit done);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            while (gaps && ($urandom % 3 == 0)) begin
                load_valid = 1'b0;
                load_data  = 8'($urandom_range(0, 255));
                tick();
            end
            case (mode)
                0:       d = 8'(i);
                2:       d = 8'((i + 1) * 17);
                default: d = 8'($urandom_range(0, 255));
            endcase
            load_valid = 1'b1;
            load_data  = d;
            load_done  = done && (i == n - 1);
            m_mem[i]   = d;
            tick();
        end
        load_valid = 1'b0;
        load_done  = 1'b0;
        chk("prog_valid_rdy", 32'(prog_valid), 32'd1);
        chk("load_ready_off", 32'(load_ready), 32'd0);
    endtask

    initial begin
        bit         seen;
        logic [7:0] a;
        for (int i = 0; i < 256; i++) m_mem[i] = 8'd0;
        rst_n      = 1'b0;
        fetch_req  = 1'b0;
        fetch_addr = 8'd0;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_data  = 8'd0;
        load_done  = 1'b0;
        #3;
        chk("rst_ack", 32'(fetch_ack), 32'd0);
        chk("rst_data", 32'(fetch_data), 32'd0);
        chk("rst_load_ready", 32'(load_ready), 32'd0);
        chk("rst_prog_valid", 32'(prog_valid), 32'd0);
        #20 rst_n = 1'b1;
        tick();

        // No program: fetches are ignored.
        fetch_req = 1'b1;
        seen      = 1'b0;
        repeat (20) begin
            tick();
            seen |= fetch_ack;
        end
        fetch_req = 1'b0;
        chk("idle_no_ack", 32'(seen), 32'd0);
        chk("idle_prog_valid", 32'(prog_valid), 32'd0);

        // Three-byte program ended by load_done.
        start_load();
        load_beats(3, 1'b0, 2, 1'b1);
        do_fetch(8'h02);

        // Full 256-word program ended by pointer wrap.
        start_load();
        load_beats(256, 1'b0, 0, 1'b0);
        do_fetch(8'hFF);
        do_fetch(8'h00);
        do_fetch(8'h10);
        do_fetch(8'h11);
        do_fetch(8'h40);
        do_fetch(8'hFF);
        do_fetch(8'h00);

        // load_start during a fetch aborts it; gapped beats land contiguously.
        fetch_req  = 1'b1;
        fetch_addr = 8'h33;
        tick();
        chk("fetch_prog_valid", 32'(prog_valid), 32'd1);
        tick();
        load_start = 1'b1;
        fetch_req  = 1'b0;
        tick();
        load_start = 1'b0;
        chk("abort_no_ack", 32'(fetch_ack), 32'd0);
        chk("abort_load_ready", 32'(load_ready), 32'd1);
        m_pf_vld = 1'b0;
        load_beats(10, 1'b1, 1, 1'b1);
        for (int i = 0; i < 10; i++) do_fetch(8'(i));

        // Random programs and fetch streams, biased towards sequential addresses.
        repeat (8) begin
            start_load();
            load_beats($urandom_range(1, 40), 1'b1, 1, 1'b1);
            repeat (6) begin
                a = ($urandom_range(0, 2) != 0) ? m_pf_addr : 8'($urandom_range(0, 255));
                do_fetch(a);
            end
        end

        // Reset in the middle of a load.
        start_load();
        for (int i = 0; i < 5; i++) begin
            load_valid = 1'b1;
            load_data  = 8'($urandom_range(0, 255));
            m_mem[i]   = load_data;
            tick();
        end
        rst_n = 1'b0;
        load_valid = 1'b0;
        #1;
        chk("mid_rst_load_ready", 32'(load_ready), 32'd0);
        chk("mid_rst_prog_valid", 32'(prog_valid), 32'd0);
        chk("mid_rst_ack", 32'(fetch_ack), 32'd0);
        chk("mid_rst_data", 32'(fetch_data), 32'd0);
        #3 rst_n = 1'b1;
        m_pf_vld = 1'b0;
        fetch_req = 1'b1;
        seen      = 1'b0;
        repeat (5) begin
            tick();
            seen |= fetch_ack;
        end
        fetch_req = 1'b0;
        chk("post_rst_no_ack", 32'(seen), 32'd0);
        chk("post_rst_idle", 32'(prog_valid | load_ready), 32'd0);

        // Storage survives reset: a short reload leaves word 4 from before reset.
        start_load();
        load_beats(3, 1'b0, 1, 1'b1);
        do_fetch(8'h04);
        do_fetch(8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
